// File: rtl/pipe_elastic_pkg.sv
// Shared definitions for the elastic inter-stage register chains of the core.
// Holds default geometry, the per-stage control struct and the occupancy width helper.
package pipe_pkg;

  localparam int PIPE_WIDTH = 32;
  localparam int PIPE_DEPTH = 3;

  typedef struct packed {
    logic valid;
    logic flush;
  } stage_ctrl_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_elastic_if.sv
// Handshake bundle between an elastic pipeline chain and its producer/consumer.
// The slave modport is the chain itself; master is the surrounding logic.
interface pipe_elastic_if #(
  parameter int WIDTH = pipe_pkg::PIPE_WIDTH,
  parameter int DEPTH = pipe_pkg::PIPE_DEPTH
) ();
  import pipe_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [DEPTH-1:0]          flush_vec;
  logic [cnt_w(DEPTH)-1:0]   occupancy;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  flush_vec,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    output flush_vec,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

endinterface

// File: rtl/pipe_elastic_slot.sv
// One stage of the elastic chain: valid/data flops, kill logic and load enable.
// Reports its next-state valid so the parent can keep a registered occupancy.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_flush,
  output logic             o_live,
  output logic             o_valid_next,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  stage_ctrl_t      w_ctrl;
  logic             w_live;
  logic             w_valid_next;
  logic             w_load;

  assign w_ctrl = '{valid: r_valid, flush: i_flush};
  assign w_live = w_ctrl.valid & ~w_ctrl.flush;

  // A stalled stage keeps only a surviving entry; a flushed one drops out at the edge.
  assign w_valid_next = i_en ? i_valid : w_live;
  assign w_load       = i_en & i_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_valid_next;
      if (w_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_live       = w_live;
  assign o_valid_next = w_valid_next;
  assign o_data       = r_data;

endmodule

// File: rtl/pipe_elastic.sv
// Elastic DEPTH-stage register chain with valid/ready, per-stage flush and stall.
// Define PIPE_BUBBLE_COLLAPSE_EN for per-stage ready (bubbles squeezed); default is lockstep.
module pipe_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = PIPE_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_elastic_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_elastic: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] w_live;
  logic [DEPTH-1:0] w_valid_next;
  logic [DEPTH-1:0] w_en;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] r_occ;

`ifdef PIPE_BUBBLE_COLLAPSE_EN
  // Ready ripples from the exit toward the entry; any empty stage absorbs a stall.
  always_comb begin
    logic v_rdy;
    w_en  = '0;
    v_rdy = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      v_rdy   = ~w_live[i] | v_rdy;
      w_en[i] = v_rdy;
    end
  end
`else
  logic w_adv;

  assign w_adv = ~w_live[DEPTH-1] | bus.out_ready;
  assign w_en  = {DEPTH{w_adv}};
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_in_valid;
    logic [WIDTH-1:0] w_in_data;

    if (i == 0) begin : g_entry
      assign w_in_valid = bus.in_valid;
      assign w_in_data  = bus.in_data;
    end else begin : g_inner
      assign w_in_valid = w_live[i-1];
      assign w_in_data  = w_data[i-1];
    end

    pipe_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_en         (w_en[i]),
      .i_valid      (w_in_valid),
      .i_data       (w_in_data),
      .i_flush      (bus.flush_vec[i]),
      .o_live       (w_live[i]),
      .o_valid_next (w_valid_next[i]),
      .o_data       (w_data[i])
    );
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + CNT_W'(w_valid_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_cnt;
    end
  end

  assign bus.in_ready  = w_en[0];
  assign bus.out_valid = w_live[DEPTH-1];
  assign bus.out_data  = w_data[DEPTH-1];
  assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_pipe_elastic.sv
// Scoreboard bench for pipe_elastic (DEPTH=3): directed stimulus pushes expected
// outputs, an independent negedge monitor pops and compares on every transfer.
module tb_pipe_elastic;
  import pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pipe_elastic_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] expQ [$];
  logic [WIDTH-1:0] expWord;
  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one word until accepted; record it as expected output only if it should survive.
  task automatic applyStimulus(input logic [31:0] data, input bit emerges);
    int guard;
    bit accepted;
    guard    = 0;
    accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    while (!accepted && guard < 64) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        if (emerges) expQ.push_back(data);
      end
      guard++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: word 0x%0h never accepted", data);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL out_unexpected: got 0x%0h, expected no transfer", bus.out_data);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("out_data", bus.out_data, expWord);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA5A5A5A5;
    bus.out_ready = 1'b1;
    bus.flush_vec = '0;
    rst_n         = 1'b0;

    $display("[TB] reset with input offered");
    @(negedge clk); @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_occupancy", 32'(bus.occupancy), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(32'hA5A5A5A5, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_occ", 32'(bus.occupancy), 32'd1);
    tick(3);
    @(negedge clk);
    checkOutput("post_rst_drain_occ", 32'(bus.occupancy), 32'd0);
    @(posedge clk); #1;

    $display("[TB] streaming with out_ready=1");
    applyStimulus(32'h1, 1'b1);
    applyStimulus(32'h2, 1'b1);
    applyStimulus(32'h3, 1'b1);
    @(negedge clk);
    checkOutput("stream_occ_full", 32'(bus.occupancy), 32'd3);
    checkOutput("stream_first_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("stream_first_data", bus.out_data, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stream_second_data", bus.out_data, 32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stream_third_data", bus.out_data, 32'h3);
    checkOutput("stream_occ_tail", 32'(bus.occupancy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stream_empty_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    $display("[TB] fill under back-pressure");
    bus.out_ready = 1'b0;
    applyStimulus(32'h10, 1'b1);
    applyStimulus(32'h20, 1'b1);
    applyStimulus(32'h30, 1'b1);
    @(negedge clk);
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_occ", 32'(bus.occupancy), 32'd3);
    checkOutput("full_head", bus.out_data, 32'h10);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("release_occ", 32'(bus.occupancy), 32'd2);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    tick(3);

    $display("[TB] middle-stage flush on a stalled full chain");
    bus.out_ready = 1'b0;
    applyStimulus(32'h11, 1'b1);
    applyStimulus(32'h22, 1'b0);
    applyStimulus(32'h33, 1'b1);
    @(negedge clk);
    checkOutput("flush_pre_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush_vec = 3'b010;
    @(negedge clk);
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    checkOutput("flush_mid_in_ready", 32'(bus.in_ready), 32'd1);
`else
    checkOutput("flush_mid_in_ready", 32'(bus.in_ready), 32'd0);
`endif
    @(posedge clk); #1;
    bus.flush_vec = '0;
    @(negedge clk);
    checkOutput("flush_mid_occ", 32'(bus.occupancy), 32'd2);
    checkOutput("flush_mid_head", bus.out_data, 32'h11);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    checkOutput("flush_mid_drain_occ", 32'(bus.occupancy), 32'd0);
    @(posedge clk); #1;

    $display("[TB] exit-stage flush while consumer is ready");
    applyStimulus(32'h77, 1'b0);
    applyStimulus(32'h88, 1'b1);
    @(posedge clk); #1;
    bus.flush_vec = 3'b100;
    @(negedge clk);
    checkOutput("flush_exit_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_exit_occ_before", 32'(bus.occupancy), 32'd2);
    @(posedge clk); #1;
    bus.flush_vec = '0;
    @(negedge clk);
    checkOutput("flush_exit_occ_after", 32'(bus.occupancy), 32'd1);
    checkOutput("flush_exit_next", bus.out_data, 32'h88);
    @(posedge clk); #1;

    $display("[TB] asynchronous reset mid-flight");
    applyStimulus(32'hC1, 1'b0);
    applyStimulus(32'hC2, 1'b0);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_occ", 32'(bus.occupancy), 32'd0);
    checkOutput("midrst_data", bus.out_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(32'h55, 1'b1);
    @(negedge clk);
    checkOutput("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lat_edge2_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("lat_edge3_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    tick(2);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_elastic.md
# pipe_elastic

Parametrised elastic pipeline register chain for the RISC-V core: DEPTH stages of WIDTH-bit payload, each with its own valid bit. It adds a valid/ready handshake, per-stage flush and stall back-pressure to the inter-stage registers. It replaces the free-running fixed delay lines between fetch, decode, execute, memory and writeback. One instance sits on each datapath bundle that must travel several stages together, such as PC, rd, and the RegWrite/ResultSrc controls.

## Interface
- WIDTH, 32, payload bits per stage
- DEPTH, 3, number of register stages (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage 0 can accept this cycle (combinational)
- in_data  input  WIDTH  payload entering stage 0
- out_valid  output  1  stage DEPTH-1 holds a live entry
- out_ready  input  1  downstream consumes this cycle
- out_data  output  WIDTH  payload of stage DEPTH-1
- flush_vec  input  DEPTH  bit i kills the entry currently held in stage i
- occupancy  output  $clog2(DEPTH+1)  registered count of valid stages

## Operation
- Per-stage state: valid_q[i], data_q[i]. Stage 0 is the entry stage and stage DEPTH-1 is the exit stage.
- Killing a stage: live[i] = valid_q[i] & ~flush_vec[i]. A flushed entry never transfers. Its stage is empty after the edge unless a new entry moves in during the same cycle.
- Exit: out_valid = live[DEPTH-1]; out_data = data_q[DEPTH-1]. A transfer occurs when out_valid & out_ready.
- Advance enables are defined under Configuration. When stage i advances:
  - valid_q[i] <= live[i-1], or in_valid for stage 0.
  - data_q[i] is loaded only when the incoming entry is live; otherwise it holds.
- in_ready = enable of stage 0. An entry is accepted when in_valid & in_ready.
- An entry accepted in cycle N is not affected by flush_vec[0] in cycle N. It can only be killed from cycle N+1 onward.
- occupancy <= popcount of next-state valid_q. It always equals the number of live entries held after the edge.
- Simultaneous flush and out_ready on stage DEPTH-1: out_valid is 0, so no transfer occurs and the entry is dropped.
- A full chain with out_ready=0:
  - In-order bubbles still fill according to mode.
  - in_ready=0 once no stage can move.

## Timing
- Reset (asynchronous assert, synchronous release by the clock edge) sets:
  - valid_q=0, data_q=0, so out_valid=0 and out_data=0
  - occupancy=0
  - in_ready=1
- Reset mid-operation discards all entries immediately. No partial transfer completes.
- Latency: an entry accepted at edge N is presented at out_valid after edge N+DEPTH-1, given no stalls.
- Throughput: 1 entry/cycle sustained with out_ready=1.
- in_ready and out_valid have a combinational dependence on out_ready and flush_vec. There is no dependence in the in_valid→in_ready direction.

## Configuration
- PIPE_BUBBLE_COLLAPSE_EN undefined (lockstep):
  - A single global enable, adv = ~live[DEPTH-1] | out_ready, is shared by all stages.
  - Bubbles travel with the pipeline. This matches the classic stall-all hazard behaviour.
- PIPE_BUBBLE_COLLAPSE_EN defined (elastic):
  - Per-stage enable: rdy[DEPTH] = out_ready; rdy[i] = ~live[i] | rdy[i+1]. Stage i advances when rdy[i].
  - Empty or flushed stages are squeezed out, so younger entries close up on a stalled head.
- Both modes produce identical results when out_ready is held at 1 and no flush occurs.

## Structure
- Shared package pipe_pkg:
  - function cnt_w(DEPTH) returning $clog2(DEPTH+1)
  - typedef for the stage control struct {valid, flush}
  - the DEPTH/WIDTH default constants used by the core's pipeline instances
- Sub-module pipe_slot holds one stage: valid/data flops, live computation, load-enable. It is instantiated DEPTH times in a generate loop. The top level holds the ready chain (or global enable), occupancy popcount and port mapping.

## Test plan
- Reset with in_valid=1, in_data=0xA5A5A5A5 asserted during reset → out_valid=0, occupancy=0, in_ready=1; no entry captured until the first edge after release.
- DEPTH=3, stream 0x1,0x2,0x3 with out_ready=1 → out_data 0x1 appears after edge 3 and then 1 entry/cycle; occupancy settles at 3.
- Fill with 0x10,0x20,0x30, out_ready=0 → in_ready=0, occupancy=3; then out_ready=1 for one cycle → 0x10 consumed, in_ready=1 in that same cycle.
- Full chain, flush_vec=3'b010, out_ready=0:
  - Lockstep build: occupancy=2 and in_ready=0.
  - Collapse build: stage 1 refills from stage 0, and in_ready=1.
- flush_vec[DEPTH-1]=1 with out_valid and out_ready=1 → out_valid=0 that cycle; the entry never appears at the output; occupancy drops by 1.
- Assert rst_n low while 2 entries are in flight → out_valid=0 immediately without a clock edge; after release, a fresh entry 0x55 emerges with correct DEPTH-cycle latency.
